// File: rtl/violation_logger.sv
// Red-light violation logger: edge-detects per-direction flags, keeps saturating
// counts, queues events in a small FIFO and drives a tick-timed alarm.
module violation_logger #(
  parameter int CNT_W       = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int ALARM_TICKS = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             viol_n,
  input  logic             viol_s,
  input  logic             viol_w,
  input  logic             viol_e,
  input  logic             tick_alarm,
  input  logic             clr,
  input  logic             ev_rd,
  output logic             ev_valid,
  output logic [1:0]       ev_dir,
  output logic [CNT_W-1:0] cnt_n,
  output logic [CNT_W-1:0] cnt_s,
  output logic [CNT_W-1:0] cnt_w,
  output logic [CNT_W-1:0] cnt_e,
  output logic [CNT_W+1:0] cnt_all,
  output logic             ovf,
  output logic             alarm
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [7:0]       ALARM_LOAD = 8'(ALARM_TICKS);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

  // Direction index: 0=N, 1=S, 2=W, 3=E (lower index has push priority).
  logic [3:0] viol_v;
  logic [3:0] rise;
  assign viol_v = {viol_e, viol_w, viol_s, viol_n};

  logic [3:0]       viol_d_q;
  logic [3:0]       pend_q, pend_d;
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [1:0]       fifo_q [FIFO_DEPTH];
  logic [CNT_W-1:0] cnt_q [4];
  logic [CNT_W-1:0] cnt_d [4];
  logic [CNT_W+1:0] cnt_all_q, cnt_all_d;
  logic             ovf_q, ovf_d;
  logic [7:0]       alarm_cnt_q, alarm_cnt_d;
  logic             alarm_q;

  logic             empty, full, pop, push;
  logic [3:0]       push_sel, push_clr, merge;
  logic [1:0]       push_dir;
  logic [2:0]       n_rise;
  logic [CNT_W+2:0] all_sum;

  assign rise  = viol_v & ~viol_d_q;
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop   = ev_rd & ~empty;
  // A full FIFO still accepts when the head leaves in the same cycle.
  assign push  = (|pend_q) & (~full | pop);

  // NOTE: always_comb uses blocking '=' and assigns every output a default first,
  // so the loop's overrides are ordered and no latch is inferred.
  always_comb begin
    push_sel = '0;
    push_dir = '0;
    for (int i = 3; i >= 0; i--) begin
      if (pend_q[i]) begin
        push_sel    = '0;
        push_sel[i] = 1'b1;
        push_dir    = 2'(i);
      end
    end
  end

  assign push_clr = push ? push_sel : 4'b0000;
  assign merge    = rise & pend_q & ~push_clr;
  assign n_rise   = {2'b00, rise[0]} + {2'b00, rise[1]} +
                    {2'b00, rise[2]} + {2'b00, rise[3]};
  assign all_sum  = {1'b0, cnt_all_q} + (CNT_W+3)'(n_rise);

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = cnt_q[i];
      if (clr)                               cnt_d[i] = '0;
      else if (rise[i] && cnt_q[i] != CNT_MAX) cnt_d[i] = cnt_q[i] + 1'b1;
    end
    if (clr)                  cnt_all_d = '0;
    else if (all_sum[CNT_W+2]) cnt_all_d = '1;
    else                      cnt_all_d = all_sum[CNT_W+1:0];
  end

  always_comb begin
    pend_d   = clr ? 4'b0000 : ((pend_q & ~push_clr) | rise);
    ovf_d    = clr ? 1'b0    : (ovf_q | (|merge));
    wr_ptr_d = clr ? '0      : wr_ptr_q + (AW+1)'(push);
    rd_ptr_d = clr ? '0      : rd_ptr_q + (AW+1)'(pop);

    alarm_cnt_d = alarm_cnt_q;
    if (clr)                                 alarm_cnt_d = '0;
    else if (|rise)                          alarm_cnt_d = ALARM_LOAD;
    else if (tick_alarm && alarm_cnt_q != 0) alarm_cnt_d = alarm_cnt_q - 8'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      viol_d_q    <= '0;
      pend_q      <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_all_q   <= '0;
      ovf_q       <= 1'b0;
      alarm_cnt_q <= '0;
      alarm_q     <= 1'b0;
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
    end else begin
      viol_d_q    <= viol_v;
      pend_q      <= pend_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_all_q   <= cnt_all_d;
      ovf_q       <= ovf_d;
      alarm_cnt_q <= alarm_cnt_d;
      alarm_q     <= (alarm_cnt_d != 0);
      for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  // NOTE: FIFO storage is not reset; reset/clr empty the pointers and ev_dir is
  // masked while empty, so stale contents are never observable.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q[AW-1:0]] <= push_dir;
  end

  assign ev_valid = ~empty;
  assign ev_dir   = empty ? 2'd0 : fifo_q[rd_ptr_q[AW-1:0]];
  assign cnt_n    = cnt_q[0];
  assign cnt_s    = cnt_q[1];
  assign cnt_w    = cnt_q[2];
  assign cnt_e    = cnt_q[3];
  assign cnt_all  = cnt_all_q;
  assign ovf      = ovf_q;
  assign alarm    = alarm_q;

endmodule

// File: tb/tb_violation_logger.sv
// Directed bench for violation_logger: a scoreboard queue holds expected event
// directions and a negedge monitor compares every FIFO pop against it.
module tb_violation_logger;

  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n, viol_n, viol_s, viol_w, viol_e, tick_alarm, clr, ev_rd;
  logic             ev_valid, ovf, alarm;
  logic [1:0]       ev_dir;
  logic [CNT_W-1:0] cnt_n, cnt_s, cnt_w, cnt_e;
  logic [CNT_W+1:0] cnt_all;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [1:0] exp_q[$];
  logic [1:0] exp_dir;

  violation_logger #(.CNT_W(CNT_W), .FIFO_DEPTH(4), .ALARM_TICKS(6)) dut (
    .clk(clk), .rst_n(rst_n),
    .viol_n(viol_n), .viol_s(viol_s), .viol_w(viol_w), .viol_e(viol_e),
    .tick_alarm(tick_alarm), .clr(clr), .ev_rd(ev_rd),
    .ev_valid(ev_valid), .ev_dir(ev_dir),
    .cnt_n(cnt_n), .cnt_s(cnt_s), .cnt_w(cnt_w), .cnt_e(cnt_e),
    .cnt_all(cnt_all), .ovf(ovf), .alarm(alarm)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; outputs read there are settled.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    exp_q.delete();
  endtask

  task automatic pop_n(input int n);
    ev_rd = 1'b1;
    tick(n);
    ev_rd = 1'b0;
  endtask

  task automatic alarm_pulse();
    tick_alarm = 1'b1;
    tick(1);
    tick_alarm = 1'b0;
    tick(1);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ev_valid"}, ev_valid, 0);
    check({tag, "_ev_dir"},   ev_dir,   0);
    check({tag, "_cnt_n"},    cnt_n,    0);
    check({tag, "_cnt_s"},    cnt_s,    0);
    check({tag, "_cnt_w"},    cnt_w,    0);
    check({tag, "_cnt_e"},    cnt_e,    0);
    check({tag, "_cnt_all"},  cnt_all,  0);
    check({tag, "_ovf"},      ovf,      0);
    check({tag, "_alarm"},    alarm,    0);
  endtask

  // Monitor: every accepted pop must match the oldest expected event.
  always @(negedge clk) begin
    if (rst_n && ev_rd && ev_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_event: got dir %0d expected none", ev_dir);
      end else begin
        exp_dir = exp_q.pop_front();
        check("event_dir", ev_dir, exp_dir);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; viol_n = 1'b0; viol_s = 1'b0; viol_w = 1'b0; viol_e = 1'b0;
    tick_alarm = 1'b0; clr = 1'b0; ev_rd = 1'b0;
    tick(3);
    check_zero("reset");
    rst_n = 1'b1;
    tick(6);

    // 1: single held-high flag gives exactly one event
    viol_n = 1'b1;
    tick(1);
    exp_q.push_back(2'd0);
    check("t1_cnt_n", cnt_n, 1);
    check("t1_cnt_all", cnt_all, 1);
    check("t1_valid_latency", ev_valid, 0);
    check("t1_alarm", alarm, 1);
    tick(1);
    check("t1_valid", ev_valid, 1);
    check("t1_dir", ev_dir, 0);
    tick(19);
    check("t1_hold_cnt_n", cnt_n, 1);
    pop_n(2);
    check("t1_empty", ev_valid, 0);
    check("t1_empty_dir", ev_dir, 0);
    viol_n = 1'b0;
    tick(1);

    // 2: three simultaneous rises queue in priority order
    pulse_clr();
    viol_s = 1'b1; viol_w = 1'b1; viol_e = 1'b1;
    tick(1);
    exp_q.push_back(2'd1); exp_q.push_back(2'd2); exp_q.push_back(2'd3);
    check("t2_cnt_all", cnt_all, 3);
    check("t2_cnt_s", cnt_s, 1);
    check("t2_cnt_e", cnt_e, 1);
    tick(1);
    check("t2_head", ev_dir, 1);
    tick(2);
    viol_s = 1'b0; viol_w = 1'b0; viol_e = 1'b0;
    pop_n(3);
    check("t2_empty", ev_valid, 0);

    // 3: FIFO full, pending wait, then merge
    pulse_clr();
    for (int i = 0; i < 6; i++) begin
      viol_e = 1'b1;
      tick(1);
      viol_e = 1'b0;
      if (i < 5) exp_q.push_back(2'd3);
      tick(1);
      if (i == 4) begin
        check("t3_ovf_before_merge", ovf, 0);
        check("t3_cnt_e5", cnt_e, 5);
      end
    end
    check("t3_cnt_e", cnt_e, 6);
    check("t3_ovf", ovf, 1);
    check("t3_valid", ev_valid, 1);
    pop_n(4);
    check("t3_fifth_valid", ev_valid, 1);
    check("t3_fifth_dir", ev_dir, 3);
    pop_n(1);
    check("t3_no_sixth", ev_valid, 0);
    check("t3_ovf_sticky", ovf, 1);

    // 4: alarm duration and reload
    pulse_clr();
    viol_n = 1'b1;
    tick(1);
    exp_q.push_back(2'd0);
    check("t4_alarm_on", alarm, 1);
    repeat (5) alarm_pulse();
    check("t4_alarm_5ticks", alarm, 1);
    alarm_pulse();
    check("t4_alarm_off", alarm, 0);
    viol_n = 1'b0;
    tick(1);
    viol_s = 1'b1;
    tick(1);
    exp_q.push_back(2'd1);
    check("t4_alarm_on2", alarm, 1);
    repeat (3) alarm_pulse();
    viol_w = 1'b1;
    tick(1);
    exp_q.push_back(2'd2);
    repeat (5) alarm_pulse();
    check("t4_reload_held", alarm, 1);
    alarm_pulse();
    check("t4_reload_off", alarm, 0);
    viol_s = 1'b0; viol_w = 1'b0;
    pop_n(3);
    check("t4_drained", ev_valid, 0);

    // 5: saturation of per-direction counter, total keeps counting
    pulse_clr();
    for (int i = 0; i < 260; i++) begin
      viol_w = 1'b1;
      tick(1);
      viol_w = 1'b0;
      tick(1);
    end
    check("t5_cnt_w_sat", cnt_w, 255);
    check("t5_cnt_all", cnt_all, 260);
    check("t5_ovf", ovf, 1);
    pulse_clr();
    check_zero("t5_clr");

    // 6: rise coincident with clr is discarded and does not re-trigger
    viol_e = 1'b1; clr = 1'b1;
    tick(1);
    clr = 1'b0;
    check("t6_cnt_e", cnt_e, 0);
    check("t6_alarm", alarm, 0);
    tick(3);
    check("t6_no_retrigger_cnt", cnt_e, 0);
    check("t6_no_retrigger_valid", ev_valid, 0);
    viol_e = 1'b0;
    tick(1);

    // 6b: reset in the middle of filling the FIFO
    viol_n = 1'b1; viol_s = 1'b1; viol_w = 1'b1;
    tick(2);
    check("t6_fill_valid", ev_valid, 1);
    check("t6_fill_cnt_all", cnt_all, 3);
    rst_n = 1'b0; viol_n = 1'b0; viol_s = 1'b0; viol_w = 1'b0;
    tick(1);
    exp_q.delete();
    check_zero("t6_reset");
    rst_n = 1'b1;
    tick(3);
    check("t6_after_reset_valid", ev_valid, 0);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
